// File: rtl/dmem_req_master.sv
// Memory-stage initiator: issues single-beat data-memory requests for load/store/stack ops,
// waits for the completion and hands valM to write-back; halts on address or timeout errors.
module dmem_req_master #(
    parameter logic [63:0] ADDR_LIMIT = 64'd8192,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [63:0] req_addr,
    output logic [63:0] req_wdata,
    input  logic        rsp_valid,
    input  logic [63:0] rsp_rdata,
    output logic        w_valid,
    output logic [3:0]  w_icode,
    output logic [63:0] w_valM,
    output logic        w_error,
    output logic        halted
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          run_q;
    logic          we_q, we_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [3:0]    icode_q, icode_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          halted_q, halted_d;
    logic [3:0]    w_icode_q, w_icode_d;
    logic [63:0]   w_valm_q, w_valm_d;
    logic          w_error_q, w_error_d;

    logic          dec_mem, dec_we, addr_err;
    logic [63:0]   dec_addr, dec_wdata;

    always_comb begin
        dec_mem   = 1'b1;
        dec_we    = 1'b0;
        dec_addr  = valE;
        dec_wdata = 64'd0;
        case (icode)
            4'h4, 4'hA: begin
                dec_we    = 1'b1;
                dec_wdata = valA;
            end
            4'h8: begin
                dec_we    = 1'b1;
                dec_wdata = valP;
            end
            4'h5: ;
            4'h9, 4'hB: dec_addr = valA;
            default: dec_mem = 1'b0;
        endcase
    end

    assign addr_err = dec_mem && (dec_addr > ADDR_LIMIT);
    assign m_ready  = run_q && (state_q == StIdle) && !halted_q;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        icode_d   = icode_q;
        timer_d   = timer_q;
        halted_d  = halted_q;
        w_icode_d = w_icode_q;
        w_valm_d  = w_valm_q;
        w_error_d = w_error_q;
        unique case (state_q)
            StIdle: begin
                if (m_valid && m_ready) begin
                    icode_d = icode;
                    we_d    = dec_we;
                    addr_d  = dec_addr;
                    wdata_d = dec_wdata;
                    if (dec_mem && !addr_err) begin
                        state_d = StReq;
                    end else begin
                        // Non-memory ops and bad addresses complete without touching memory
                        state_d   = StDone;
                        w_icode_d = icode;
                        w_valm_d  = 64'd0;
                        w_error_d = addr_err;
                    end
                end
            end
            StReq: begin
                if (req_ready) begin
                    state_d = StWait;
                    timer_d = '0;
                end
            end
            StWait: begin
                if (rsp_valid) begin
                    state_d   = StDone;
                    w_icode_d = icode_q;
                    w_valm_d  = we_q ? 64'd0 : rsp_rdata;
                    w_error_d = 1'b0;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    state_d   = StDone;
                    w_icode_d = icode_q;
                    w_valm_d  = 64'd0;
                    w_error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (w_error_q) halted_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            run_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            icode_q   <= 4'd0;
            timer_q   <= '0;
            halted_q  <= 1'b0;
            w_icode_q <= 4'd0;
            w_valm_q  <= 64'd0;
            w_error_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            icode_q   <= icode_d;
            timer_q   <= timer_d;
            halted_q  <= halted_d;
            w_icode_q <= w_icode_d;
            w_valm_q  <= w_valm_d;
            w_error_q <= w_error_d;
        end
    end

    assign req_valid = (state_q == StReq);
    assign req_we    = req_valid && we_q;
    assign req_addr  = req_valid ? addr_q : 64'd0;
    assign req_wdata = req_valid ? wdata_q : 64'd0;
    assign w_valid   = (state_q == StDone);
    assign w_icode   = w_icode_q;
    assign w_valM    = w_valm_q;
    assign w_error   = w_error_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_dmem_req_master.sv
// Randomized bench for dmem_req_master: a transaction-level model predicts each request
// and write-back result, and every DUT observation is compared on the falling edge.
module tb_dmem_req_master;

    localparam int unsigned TIMEOUT = 15;
    localparam logic [63:0] LIMIT   = 64'd8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic        req_valid, req_ready, req_we;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        w_valid, w_error, halted;
    logic [3:0]  w_icode;
    logic [63:0] w_valM;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_req_master #(
        .ADDR_LIMIT(LIMIT),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .icode    (icode),
        .valA     (valA),
        .valE     (valE),
        .valP     (valP),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .w_valid  (w_valid),
        .w_icode  (w_icode),
        .w_valM   (w_valM),
        .w_error  (w_error),
        .halted   (halted)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level meaning of each instruction code
    task automatic model(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                         input logic [63:0] p, output bit mem, output bit we, output bit err,
                         output logic [63:0] addr, output logic [63:0] wdata);
        mem   = 1'b1;
        we    = 1'b0;
        addr  = e;
        wdata = 64'd0;
        if (ic == 4'h4 || ic == 4'hA) begin
            we = 1'b1;
            wdata = a;
        end else if (ic == 4'h8) begin
            we = 1'b1;
            wdata = p;
        end else if (ic == 4'h9 || ic == 4'hB) begin
            addr = a;
        end else if (ic != 4'h5) begin
            mem = 1'b0;
        end
        err = mem && (addr > LIMIT);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m_valid = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_m_ready", m_ready, 0);
        check_eq("rst_req_valid", req_valid, 0);
        check_eq("rst_req_addr", req_addr, 0);
        check_eq("rst_w_valid", w_valid, 0);
        check_eq("rst_w_valM", w_valM, 0);
        check_eq("rst_w_icode", w_icode, 0);
        check_eq("rst_w_error", w_error, 0);
        check_eq("rst_halted", halted, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_m_ready", m_ready, 1);
    endtask

    // rsp_delay = index of the WAIT cycle that carries rsp_valid; > TIMEOUT means never
    task automatic run_txn(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                           input logic [63:0] p, input int ready_delay, input int rsp_delay);
        bit mem, we, err, exp_err;
        logic [63:0] addr, wdata, valm, rdata;
        model(ic, a, e, p, mem, we, err, addr, wdata);
        rdata = {$urandom, $urandom};
        exp_err = err;
        valm = 64'd0;
        check_eq("idle_m_ready", m_ready, 1);
        m_valid = 1'b1;
        icode = ic;
        valA = a;
        valE = e;
        valP = p;
        @(negedge clk);
        m_valid = 1'b0;
        icode = 4'($urandom);
        valA = {$urandom, $urandom};
        valE = {$urandom, $urandom};
        valP = {$urandom, $urandom};
        if (mem && !err) begin
            for (int k = 0; k <= ready_delay; k++) begin
                check_eq("req_valid", req_valid, 1);
                check_eq("req_we", req_we, we);
                check_eq("req_addr", req_addr, addr);
                check_eq("req_wdata", req_wdata, wdata);
                check_eq("req_m_ready", m_ready, 0);
                req_ready = (k == ready_delay);
                @(negedge clk);
            end
            req_ready = 1'b0;
            for (int k = 0; k <= int'(TIMEOUT); k++) begin
                check_eq("wait_req_valid", req_valid, 0);
                check_eq("wait_w_valid", w_valid, 0);
                rsp_valid = (k == rsp_delay);
                rsp_rdata = (k == rsp_delay) ? rdata : {$urandom, $urandom};
                @(negedge clk);
                rsp_valid = 1'b0;
                if (k == rsp_delay) break;
            end
            exp_err = (rsp_delay > int'(TIMEOUT));
            valm = (exp_err || we) ? 64'd0 : rdata;
        end else begin
            check_eq("nomem_req_valid", req_valid, 0);
        end
        check_eq("done_w_valid", w_valid, 1);
        check_eq("done_w_icode", w_icode, ic);
        check_eq("done_w_valM", w_valM, valm);
        check_eq("done_w_error", w_error, exp_err);
        @(negedge clk);
        check_eq("after_w_valid", w_valid, 0);
        check_eq("hold_w_valM", w_valM, valm);
        check_eq("hold_w_icode", w_icode, ic);
        check_eq("after_halted", halted, exp_err);
        check_eq("after_m_ready", m_ready, !exp_err);
    endtask

    task automatic halt_probe();
        m_valid = 1'b1;
        icode = 4'h5;
        valE = 64'h10;
        repeat (3) begin
            @(negedge clk);
            check_eq("halt_m_ready", m_ready, 0);
            check_eq("halt_req_valid", req_valid, 0);
            check_eq("halt_w_valid", w_valid, 0);
        end
        m_valid = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return LIMIT + 64'd1 + 64'($urandom_range(0, 1000));
        if (r == 1) return LIMIT;
        if (r == 2) return {$urandom, $urandom};
        return 64'($urandom_range(0, 8192));
    endfunction

    initial begin
        logic [3:0] ic;
        int rd, sd;
        rst_n = 1'b1;
        m_valid = 1'b0;
        icode = 4'd0;
        valA = 64'd0;
        valE = 64'd0;
        valP = 64'd0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 64'd0;

        do_reset();
        run_txn(4'h5, 64'h0, 64'h40, 64'h0, 0, 0);
        run_txn(4'h8, 64'h7, 64'h1F8, 64'h123, 3, 2);
        run_txn(4'h0, 64'h1, 64'h2, 64'h3, 0, 0);
        run_txn(4'hB, 64'h100, 64'h0, 64'h0, 0, int'(TIMEOUT));
        run_txn(4'h4, 64'h55, LIMIT, 64'h0, 1, 1);
        run_txn(4'hB, 64'h100, 64'h0, 64'h0, 0, 99);
        halt_probe();
        do_reset();
        run_txn(4'h4, 64'h1, 64'd8193, 64'h0, 0, 0);
        halt_probe();
        do_reset();

        // Reset while waiting for a response; the late response must be ignored
        check_eq("rw_m_ready", m_ready, 1);
        m_valid = 1'b1;
        icode = 4'h5;
        valE = 64'h80;
        req_ready = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        @(negedge clk);
        req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_valid = 1'b1;
        rsp_rdata = 64'hBEEF;
        @(negedge clk);
        rsp_valid = 1'b0;
        repeat (3) begin
            check_eq("rw_w_valid", w_valid, 0);
            check_eq("rw_req_valid", req_valid, 0);
            check_eq("rw_m_ready", m_ready, 1);
            check_eq("rw_w_valM", w_valM, 0);
            @(negedge clk);
        end

        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 5))
                    0: ic = 4'h4;
                    1: ic = 4'hA;
                    2: ic = 4'h8;
                    3: ic = 4'h5;
                    4: ic = 4'h9;
                    default: ic = 4'hB;
                endcase
            end else begin
                ic = 4'($urandom);
            end
            rd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            case ($urandom_range(0, 7))
                0: sd = int'(TIMEOUT);
                1: sd = int'(TIMEOUT) + 1;
                2: sd = $urandom_range(0, TIMEOUT);
                default: sd = $urandom_range(0, 3);
            endcase
            run_txn(ic, rand_addr(), rand_addr(), {$urandom, $urandom}, rd, sd);
            if (halted) do_reset();
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_eq("gap_w_valid", w_valid, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
